// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control bundle layout, field indices and constants
// used by the decode/execute boundary.
package pipe_pkg;

  localparam int CTRL_BITS       = 10;
  localparam int CTRL_BRANCH     = 0;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_REG_WRITE  = 2;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_MEM_READ   = 4;
  localparam int CTRL_ALU_SRC    = 5;
  localparam int CTRL_ALU_OP_LSB = 6;
  localparam int CTRL_ALU_OP_MSB = 9;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
  } ctrl_t;

  localparam int unsigned           ZERO_REG    = 0;
  localparam logic [CTRL_BITS-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the EX-stage load and the ID instruction.
// Flush overrides the stall so a killed instruction never holds the front end.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rn,
  input  logic [REG_AW-1:0] id_rm,
  input  logic              id_uses_rm,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              flush,
  output logic              haz,
  output logic              stall_id
);

  localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

  logic src_match;

  always_comb begin
    src_match = (ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm));
    haz       = id_valid && ex_valid && ex_mem_read && (ex_rd != ZR) && src_match;
    stall_id  = haz && !flush;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with same-cycle write-back bypass, load-use stall
// bubble insertion, branch flush and saturating stall/flush counters.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ID_VALID,
  input  logic [DATA_W-1:0] ID_PC,
  input  logic [REG_AW-1:0] ID_RN,
  input  logic [REG_AW-1:0] ID_RM,
  input  logic              ID_USES_RM,
  input  logic [REG_AW-1:0] ID_RD,
  input  logic [DATA_W-1:0] ID_IMM,
  input  logic [CTRL_W-1:0] ID_CTRL,
  input  logic [DATA_W-1:0] RF_DATA_A,
  input  logic [DATA_W-1:0] RF_DATA_B,
  input  logic              WB_REG_WRITE,
  input  logic [REG_AW-1:0] WB_WRITE_REG,
  input  logic [DATA_W-1:0] WB_WRITE_DATA,
  input  logic              FLUSH,
  output logic              STALL_ID,
  output logic              EX_VALID,
  output logic [DATA_W-1:0] EX_PC,
  output logic [DATA_W-1:0] EX_DATA_A,
  output logic [DATA_W-1:0] EX_DATA_B,
  output logic [DATA_W-1:0] EX_IMM,
  output logic [REG_AW-1:0] EX_RN,
  output logic [REG_AW-1:0] EX_RM,
  output logic [REG_AW-1:0] EX_RD,
  output logic [CTRL_W-1:0] EX_CTRL,
  output logic [CNT_W-1:0]  STALL_CNT,
  output logic [CNT_W-1:0]  FLUSH_CNT
);

  localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

  logic              haz;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  hazard_detect #(
    .REG_AW(REG_AW)
  ) u_hazard (
    .id_valid   (ID_VALID),
    .id_rn      (ID_RN),
    .id_rm      (ID_RM),
    .id_uses_rm (ID_USES_RM),
    .ex_valid   (EX_VALID),
    .ex_mem_read(EX_CTRL[CTRL_MEM_READ]),
    .ex_rd      (EX_RD),
    .flush      (FLUSH),
    .haz        (haz),
    .stall_id   (STALL_ID)
  );

  // The register file writes on the same edge we capture, so its read port
  // still shows the old value; take the write-back data directly instead.
  always_comb begin
    op_a = RF_DATA_A;
    op_b = RF_DATA_B;
    if (WB_REG_WRITE && (WB_WRITE_REG == ID_RN)) op_a = WB_WRITE_DATA;
    if (WB_REG_WRITE && (WB_WRITE_REG == ID_RM)) op_b = WB_WRITE_DATA;
    if (ID_RN == ZR) op_a = '0;
    if (ID_RM == ZR) op_b = '0;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      EX_VALID  <= 1'b0;
      EX_PC     <= '0;
      EX_DATA_A <= '0;
      EX_DATA_B <= '0;
      EX_IMM    <= '0;
      EX_RN     <= '0;
      EX_RM     <= '0;
      EX_RD     <= '0;
      EX_CTRL   <= CTRL_W'(BUBBLE_CTRL);
    end else if (FLUSH || haz) begin
      EX_VALID  <= 1'b0;
      EX_PC     <= '0;
      EX_DATA_A <= '0;
      EX_DATA_B <= '0;
      EX_IMM    <= '0;
      EX_RN     <= '0;
      EX_RM     <= '0;
      EX_RD     <= '0;
      EX_CTRL   <= CTRL_W'(BUBBLE_CTRL);
    end else begin
      EX_VALID  <= ID_VALID;
      EX_PC     <= ID_PC;
      EX_DATA_A <= op_a;
      EX_DATA_B <= op_b;
      EX_IMM    <= ID_IMM;
      EX_RN     <= ID_RN;
      EX_RM     <= ID_RM;
      EX_RD     <= ID_RD;
      EX_CTRL   <= ID_VALID ? ID_CTRL : CTRL_W'(BUBBLE_CTRL);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      STALL_CNT <= '0;
      FLUSH_CNT <= '0;
    end else if (FLUSH) begin
      if (ID_VALID && (FLUSH_CNT != '1)) FLUSH_CNT <= FLUSH_CNT + CNT_W'(1);
    end else if (haz) begin
      if (STALL_CNT != '1) STALL_CNT <= STALL_CNT + CNT_W'(1);
    end
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register between the register file read ports and the execute stage. It captures register-file read data plus decoded fields and control for one instruction per cycle. It bypasses the same-cycle write-back value, because the register file writes on the clock edge while reads are asynchronous. It also detects load-use hazards, stalling ID for one cycle and inserting a bubble, and it handles branch flush.

Parameters:
DATA_W, 64, datapath width (register data, PC, immediate)
REG_AW, 5, register index width
CTRL_W, 10, packed control bundle width (layout in shared package)
CNT_W, 16, width of saturating stall/flush counters

Ports:
CLK  in  1  system clock, all state updates on rising edge
RST_N  in  1  synchronous active-low reset
ID_VALID  in  1  ID holds a valid instruction
ID_PC  in  DATA_W  PC of ID instruction
ID_RN  in  REG_AW  source A index (also drives READ_REG_A)
ID_RM  in  REG_AW  source B index (also drives READ_REG_B)
ID_USES_RM  in  1  instruction actually reads RM
ID_RD  in  REG_AW  destination index
ID_IMM  in  DATA_W  sign-extended immediate
ID_CTRL  in  CTRL_W  decoded control bundle
RF_DATA_A  in  DATA_W  register file DATA_OUT_A
RF_DATA_B  in  DATA_W  register file DATA_OUT_B
WB_REG_WRITE  in  1  same signal as register file REG_WRITE_ENABLE
WB_WRITE_REG  in  REG_AW  same as register file WRITE_REG
WB_WRITE_DATA  in  DATA_W  same as register file WRITE_DATA
FLUSH  in  1  taken branch; kill the ID instruction
STALL_ID  out  1  combinational; hold PC and IF/ID this cycle
EX_VALID, EX_PC, EX_DATA_A, EX_DATA_B, EX_IMM, EX_RN, EX_RM, EX_RD, EX_CTRL  out  matching widths  registered EX-stage copies
STALL_CNT  out  CNT_W  load-use stalls since reset, saturating
FLUSH_CNT  out  CNT_W  flushes of a valid ID instruction since reset, saturating

Behaviour:
- Reset (RST_N=0 at edge): all EX_* outputs and both counters go to 0. STALL_ID is 0 while EX_VALID=0. Reset mid-stall discards the pending instruction.
- Register 0 is hardwired zero. It never matches for bypass or hazard purposes.
- Bypass (combinational, before the register):
  - opA = WB_WRITE_DATA if WB_REG_WRITE and WB_WRITE_REG==ID_RN and ID_RN!=0; otherwise RF_DATA_A.
  - opB uses the same rule with ID_RM.
  - If ID_RN==0 the value is 0 regardless of bypass (same for ID_RM).
- Hazard: haz = ID_VALID & EX_VALID & EX_CTRL.MEM_READ & EX_RD!=0 & (EX_RD==ID_RN | (ID_USES_RM & EX_RD==ID_RM)).
- STALL_ID = haz & ~FLUSH.
- Per-edge priority:
  1. FLUSH: load a bubble. FLUSH_CNT increments if ID_VALID.
  2. Else if haz: load a bubble. STALL_CNT increments.
  3. Else: load ID fields, opA/opB, and EX_VALID=ID_VALID.
- Bubble: EX_VALID=0 and EX_CTRL=0 (no REG_WRITE, MEM_READ or MEM_WRITE). Data fields are don't-care but driven to 0.
- A stall lasts exactly one cycle: the bubble clears EX_CTRL.MEM_READ. The held instruction is then re-captured and picks up the loaded value through the WB bypass or the register file later.
- If ID_VALID=0, the stage loads a non-valid entry with zero control. Hazards are not evaluated.
- Counters saturate at all-ones and do not wrap.
- Latency: 1 cycle from ID to EX_*. Throughput is 1 per cycle with no hazards.

Decomposition:
- Shared package pipe_pkg holds:
  - the CTRL_W bundle layout: ALU_OP[3:0], ALU_SRC, MEM_READ, MEM_WRITE, REG_WRITE, MEM_TO_REG, BRANCH;
  - field-index constants;
  - the ZERO_REG=0 constant;
  - the BUBBLE_CTRL=0 constant.
- One natural sub-module: hazard_detect (combinational haz/STALL_ID logic), reusable by later forwarding work.
- Bypass muxes and the registers stay in id_ex_stage.

Test Plan:
- Plain pass: ID_RN=1, ID_RM=2, RF_DATA_A=0x11, RF_DATA_B=0x22, ID_VALID=1 -> next edge EX_DATA_A=0x11, EX_DATA_B=0x22, EX_VALID=1, STALL_ID=0.
- WB bypass: WB_REG_WRITE=1, WB_WRITE_REG=3, WB_WRITE_DATA=0xDEAD, ID_RN=3, RF_DATA_A=0 (stale) -> EX_DATA_A=0xDEAD. Repeat with WB_WRITE_REG=0 and ID_RN=0 -> EX_DATA_A=0.
- Load-use: EX holds MEM_READ with EX_RD=4; ID_RN=4 -> STALL_ID=1 for exactly one cycle, next EX_VALID=0 with EX_CTRL=0, STALL_CNT=1; the following edge captures the instruction with EX_VALID=1.
- No false hazard:
  - EX_RD=4 with MEM_READ; ID_RM=4 with ID_USES_RM=0 -> STALL_ID=0.
  - EX_RD=0 with MEM_READ and ID_RN=0 -> STALL_ID=0.
- Flush beats stall: haz true and FLUSH=1 -> STALL_ID=0, bubble loaded, FLUSH_CNT=1, STALL_CNT unchanged.
- Reset mid-stall: during STALL_ID=1 assert RST_N=0 for one edge -> all EX_* and counters 0, STALL_ID=0; saturation check: force 2^16 stalls -> STALL_CNT holds 0xFFFF.
